// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
// Module   : md_unit
// Purpose  : EX-stage multiply/divide unit holding the architectural HI/LO
//            registers. mult/multu/div/divu run for a fixed number of cycles
//            and write HI/LO only on completion; mthi/mtlo write in one cycle.
// Ports    : clk, reset      - clock, synchronous active-high reset
//            start, md_op    - qualified operation request (0..7 encoding)
//            rs_data, rt_data- operands A / B
//            busy            - registered, long operation in flight
//            stall_req       - combinational IF/ID freeze request
//            hi, lo          - registered architectural HI / LO
// Revision : 1.0 - initial release
// ============================================================================
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] c_OP_MULT  = 3'd1;
    localparam logic [2:0] c_OP_MULTU = 3'd2;
    localparam logic [2:0] c_OP_DIV   = 3'd3;
    localparam logic [2:0] c_OP_DIVU  = 3'd4;
    localparam logic [2:0] c_OP_MTHI  = 3'd5;
    localparam logic [2:0] c_OP_MTLO  = 3'd6;

    localparam int c_MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_CNT_W   = $clog2(c_MAX_CYC + 1);

    localparam logic [c_CNT_W-1:0] c_MULT_CNT = c_CNT_W'(MULT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_DIV_CNT  = c_CNT_W'(DIV_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ZERO = '0;

    // State
    logic               busy_q, busy_d;
    logic [c_CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    logic [31:0]        phi_q, phi_d;
    logic [31:0]        plo_q, plo_d;
    logic               dz_q, dz_d;

    // Datapath
    logic        w_is_long;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_div_signed;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_den;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quo;
    logic [31:0] w_rem;

    assign w_is_long = start & ((md_op == c_OP_MULT) | (md_op == c_OP_MULTU) |
                                (md_op == c_OP_DIV)  | (md_op == c_OP_DIVU));
    assign stall_req = busy_q | w_is_long;

    // Low 64 bits of the sign-extended product equal the signed 64-bit product.
    assign w_prod_s = {{32{rs_data[31]}}, rs_data} * {{32{rt_data[31]}}, rt_data};
    assign w_prod_u = {32'd0, rs_data} * {32'd0, rt_data};

    // Signed division done on magnitudes: quotient negated when signs differ,
    // remainder follows the dividend. 0x80000000 / -1 falls out naturally as
    // 0x80000000 remainder 0, so no overflow special case is needed.
    assign w_div_signed = (md_op == c_OP_DIV);
    assign w_a_mag = (w_div_signed & rs_data[31]) ? (32'd0 - rs_data) : rs_data;
    assign w_b_mag = (w_div_signed & rt_data[31]) ? (32'd0 - rt_data) : rt_data;
    // Divide-by-zero result is discarded; substitute 1 to keep the divider defined.
    assign w_den   = (rt_data == 32'd0) ? 32'd1 : w_b_mag;
    assign w_q_mag = w_a_mag / w_den;
    assign w_r_mag = w_a_mag % w_den;
    assign w_quo   = (w_div_signed & (rs_data[31] ^ rt_data[31])) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_rem   = (w_div_signed & rs_data[31]) ? (32'd0 - w_r_mag) : w_r_mag;

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        phi_d  = phi_q;
        plo_d  = plo_q;
        dz_d   = dz_q;
        if (busy_q) begin
            // Any start while busy is ignored entirely.
            if (cnt_q == c_CNT_ONE) begin
                busy_d = 1'b0;
                cnt_d  = c_CNT_ZERO;
                dz_d   = 1'b0;
                if (!dz_q) begin
                    hi_d = phi_q;
                    lo_d = plo_q;
                end
            end else begin
                cnt_d = cnt_q - c_CNT_ONE;
            end
        end else if (start) begin
            case (md_op)
                c_OP_MULT: begin
                    {phi_d, plo_d} = w_prod_s;
                    cnt_d  = c_MULT_CNT;
                    busy_d = 1'b1;
                    dz_d   = 1'b0;
                end
                c_OP_MULTU: begin
                    {phi_d, plo_d} = w_prod_u;
                    cnt_d  = c_MULT_CNT;
                    busy_d = 1'b1;
                    dz_d   = 1'b0;
                end
                c_OP_DIV, c_OP_DIVU: begin
                    phi_d  = w_rem;
                    plo_d  = w_quo;
                    cnt_d  = c_DIV_CNT;
                    busy_d = 1'b1;
                    dz_d   = (rt_data == 32'd0);
                end
                c_OP_MTHI: hi_d = rs_data;
                c_OP_MTLO: lo_d = rs_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= 1'b0;
            cnt_q  <= c_CNT_ZERO;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            phi_q  <= 32'd0;
            plo_q  <= 32'd0;
            dz_q   <= 1'b0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            phi_q  <= phi_d;
            plo_q  <= plo_d;
            dz_q   <= dz_d;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_md_unit
// Purpose  : Self-checking bench for md_unit. The driver applies one request
//            per cycle, advances an arithmetic reference model and pushes each
//            accepted long operation's expected HI/LO and busy length into a
//            scoreboard; the monitor pops and compares when busy drops.
// Revision : 1.0 - initial release
// ============================================================================
module tb_md_unit;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;

    md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .md_op     (md_op),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .busy      (busy),
        .stall_req (stall_req),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ehi;
        logic [31:0] elo;
        int          cyc;
    } entry_t;

    entry_t scb[$];

    int          n_checks = 0;
    int          n_fail   = 0;
    logic        armed    = 1'b0;
    logic        rst_at_edge = 1'b0;

    // Reference model: architectural state as seen by the DUT in the current cycle.
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    int          m_busy = 0;
    logic [31:0] m_phi = 32'd0;
    logic [31:0] m_plo = 32'd0;

    always @(posedge clk) rst_at_edge <= reset;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Result of a long op from plain 64-bit arithmetic; div-by-zero keeps HI/LO.
    function automatic void model_long(input logic [2:0] op, input logic [31:0] a, b,
                                       input logic [31:0] ch, cl,
                                       output logic [31:0] rh, output logic [31:0] rl);
        longint      sa, sbv, q, r;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        rh = ch;
        rl = cl;
        case (op)
            3'd1: begin p = 64'(sa * sbv); rh = p[63:32]; rl = p[31:0]; end
            3'd2: begin p = {32'd0, a} * {32'd0, b}; rh = p[63:32]; rl = p[31:0]; end
            3'd3: if (b != 32'd0) begin q = sa / sbv; r = sa % sbv; rh = r[31:0]; rl = q[31:0]; end
            3'd4: if (b != 32'd0) begin rh = a % b; rl = a / b; end
            default: ;
        endcase
    endfunction

    // One clock cycle of stimulus; returns 1 time unit after the edge.
    task automatic cycle(input logic r, input logic s, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        logic [31:0] nh, nl, ph, pl;
        int          nb;
        logic        is_long, push;
        entry_t      e;
        reset = r; start = s; md_op = op; rs_data = a; rt_data = b;
        #1;
        is_long = s && (op >= 3'd1) && (op <= 3'd4);
        check("stall_req", {31'd0, stall_req}, {31'd0, (m_busy > 0) || is_long});
        nh = m_hi; nl = m_lo; nb = m_busy; ph = m_phi; pl = m_plo; push = 1'b0;
        if (r) begin
            nh = 32'd0; nl = 32'd0; nb = 0;
        end else if (m_busy > 0) begin
            nb = m_busy - 1;
            if (nb == 0) begin nh = m_phi; nl = m_plo; end
        end else if (s) begin
            if (is_long) begin
                model_long(op, a, b, m_hi, m_lo, ph, pl);
                nb = (op <= 3'd2) ? MULT_N : DIV_N;
                e.ehi = ph; e.elo = pl; e.cyc = nb;
                push = 1'b1;
            end else if (op == 3'd5) nh = a;
            else if (op == 3'd6) nl = a;
        end
        @(posedge clk);
        m_hi = nh; m_lo = nl; m_busy = nb; m_phi = ph; m_plo = pl;
        if (r) scb.delete();
        if (push) scb.push_back(e);
        if (r) armed = 1'b1;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    endtask

    task automatic expect_hilo(input string tag, input logic [31:0] eh, input logic [31:0] el);
        check({tag, "_hi"}, hi, eh);
        check({tag, "_lo"}, lo, el);
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(1, 9));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: per-cycle state check plus scoreboard pop on completion.
    initial begin : monitor
        logic   prev_busy;
        int     bcnt;
        entry_t e;
        prev_busy = 1'b0;
        bcnt = 0;
        wait (armed);
        forever begin
            @(negedge clk);
            check("busy", {31'd0, busy}, {31'd0, m_busy > 0});
            check("hi", hi, m_hi);
            check("lo", lo, m_lo);
            if (busy) begin
                bcnt++;
            end else begin
                if (prev_busy && !rst_at_edge) begin
                    if (scb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL scb_underflow: completion seen with empty scoreboard at %0t", $time);
                    end else begin
                        e = scb.pop_front();
                        check("scb_hi", hi, e.ehi);
                        check("scb_lo", lo, e.elo);
                        check("busy_len", 32'(bcnt), 32'(e.cyc));
                    end
                end
                bcnt = 0;
            end
            prev_busy = busy;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : driver
        logic        r, s;
        logic [2:0]  op;
        reset = 1'b1; start = 1'b0; md_op = 3'd0; rs_data = 32'd0; rt_data = 32'd0;
        cycle(1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
        cycle(1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
        expect_hilo("reset", 32'd0, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);

        // Signed multiply -3 * 5
        cycle(1'b0, 1'b1, 3'd1, 32'hFFFF_FFFD, 32'd5);
        idle(MULT_N);
        expect_hilo("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFF1);

        // Unsigned multiply then back-to-back mult in the completion cycle
        cycle(1'b0, 1'b1, 3'd2, 32'hFFFF_FFFF, 32'd2);
        idle(MULT_N);
        expect_hilo("multu", 32'h0000_0001, 32'hFFFF_FFFE);
        check("b2b_idle", {31'd0, busy}, 32'd0);
        cycle(1'b0, 1'b1, 3'd1, 32'd7, 32'd6);
        check("b2b_busy", {31'd0, busy}, 32'd1);
        idle(MULT_N);
        expect_hilo("mult_b2b", 32'd0, 32'd42);

        // Divides
        cycle(1'b0, 1'b1, 3'd3, 32'hFFFF_FFF9, 32'd2);
        idle(DIV_N);
        expect_hilo("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        cycle(1'b0, 1'b1, 3'd4, 32'hFFFF_FFF9, 32'd2);
        idle(DIV_N);
        expect_hilo("divu", 32'h0000_0001, 32'h7FFF_FFFC);
        cycle(1'b0, 1'b1, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        idle(DIV_N);
        expect_hilo("div_ovf", 32'h0000_0000, 32'h8000_0000);

        // MTHI then divide by zero leaves HI/LO untouched
        cycle(1'b0, 1'b1, 3'd5, 32'h1234_5678, 32'd0);
        expect_hilo("mthi", 32'h1234_5678, 32'h8000_0000);
        cycle(1'b0, 1'b1, 3'd3, 32'd99, 32'd0);
        idle(DIV_N);
        expect_hilo("div0", 32'h1234_5678, 32'h8000_0000);

        // Requests while busy are ignored
        cycle(1'b0, 1'b1, 3'd1, 32'd3, 32'd4);
        cycle(1'b0, 1'b1, 3'd6, 32'hAAAA_5555, 32'd0);
        cycle(1'b0, 1'b1, 3'd1, 32'd9, 32'd9);
        idle(MULT_N - 2);
        expect_hilo("ignored", 32'd0, 32'd12);

        // Reset in the third busy cycle of a divide aborts it
        cycle(1'b0, 1'b1, 3'd3, 32'd100, 32'd7);
        idle(2);
        cycle(1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        expect_hilo("abort", 32'd0, 32'd0);
        idle(DIV_N + 2);
        expect_hilo("abort_late", 32'd0, 32'd0);

        // Reset concurrent with start: not accepted
        cycle(1'b1, 1'b1, 3'd1, 32'd5, 32'd5);
        check("rst_start_busy", {31'd0, busy}, 32'd0);
        idle(MULT_N + 1);
        expect_hilo("rst_start", 32'd0, 32'd0);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 59) == 0);
            s  = ($urandom_range(0, 3) != 0);
            op = 3'($urandom_range(0, 7));
            cycle(r, s, op, rand_operand(), rand_operand());
        end
        idle(DIV_N + 2);
        check("scb_drained", 32'(scb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/md_unit.md
# md_unit

Multi-cycle multiply/divide unit with architectural HI/LO registers, sitting in the EX stage alongside the ALU, directly upstream of the memory stage. It executes mult/multu/div/divu over a fixed number of cycles and mthi/mtlo in one cycle. It holds HI/LO for mfhi/mflo, whose value travels down the pipeline as the EX result. It also raises the stall request the hazard unit uses to freeze IF/ID while an operation is in flight.

## Interface
- MULT_CYCLES, 5, busy duration of mult/multu (≥1)
- DIV_CYCLES, 10, busy duration of div/divu (≥1)

- clk  in  1  clock; one clock, all state on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  qualifies md_op this cycle (EX holds a valid, non-flushed md instruction)
- md_op  in  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE)
- rs_data  in  32  operand A (dividend / multiplicand / mthi-mtlo source)
- rt_data  in  32  operand B (divisor / multiplier)
- busy  out  1  registered; long operation in flight
- stall_req  out  1  combinational: busy | (start & md_op∈{1..4})
- hi  out  32  registered HI
- lo  out  32  registered LO

## Operation
- Accept condition: start=1, busy=0, md_op valid non-NONE. Accepted ops only; otherwise state unchanged.
- MULT/MULTU accept: compute signed/unsigned 64-bit product of rs_data×rt_data into pending {p_hi,p_lo}; load counter=MULT_CYCLES; busy←1.
- DIV/DIVU accept: pending p_lo=quotient, p_hi=remainder; signed quotient truncates toward zero, remainder takes dividend's sign; counter=DIV_CYCLES; busy←1.
- Signed overflow: 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0x00000000.
- Divide by zero (rt_data=0, DIV or DIVU): still busy DIV_CYCLES; on completion hi/lo left unchanged.
- MTHI: hi←rs_data at the edge; MTLO: lo←rs_data. No busy.
- While busy: each edge decrements counter; at the edge where counter==1, hi/lo←pending (unless div-by-zero flag), busy←0, counter←0.
- HI/LO are never modified before completion; mfhi/mflo during busy are prevented by the stall, not by this block.
- start with any op while busy: ignored entirely (hazard unit must not issue; verification asserts this never happens in-system, bench checks it is ignored).
- Reset: hi=0, lo=0, busy=0, counter=0, pending and div-by-zero flag cleared. Reset mid-operation aborts; result discarded; hi/lo=0.
- Reset and start in the same cycle: reset wins.

## Timing
- Accept at edge ending cycle T: busy=1 in cycles T+1 … T+N (N=MULT_CYCLES or DIV_CYCLES), exactly N cycles.
- Result visible on hi/lo from cycle T+N+1; busy=0 in the same cycle.
- A new long op may be accepted in cycle T+N+1 (back-to-back, no bubble).
- stall_req high in cycle T (accept cycle) and T+1 … T+N; low in T+N+1 unless a new op starts.
- MTHI/MTLO in cycle T: new value visible in T+1.
- Outputs hi, lo, busy come directly from flops; stall_req is the only combinational output.
- Counter width ≥ clog2(max(MULT_CYCLES,DIV_CYCLES)+1).

## Test plan
- Reset, then MULT rs=0xFFFFFFFD (−3), rt=5 → busy high exactly 5 cycles, hi/lo unchanged (0/0) during busy; then hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU rs=0xFFFFFFFF, rt=2 → hi=0x00000001, lo=0xFFFFFFFE after 5 cycles; MULT immediately in the completion cycle accepted with no gap.
- DIV rs=0xFFFFFFF9 (−7), rt=2 → busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU same operands → lo=0x7FFFFFFC, hi=0x00000001. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- MTHI 0x12345678 then DIV by 0 → busy 10 cycles, hi stays 0x12345678, lo stays prior value.
- MTLO 0xAAAA5555 and a second MULT asserted with start during busy → both ignored; final hi/lo equal the first MULT's result; stall_req=1 throughout.
- Reset asserted in 3rd busy cycle of DIV → next cycle busy=0, hi=lo=0, no later write-back; reset concurrent with start → op not accepted.
